// File: rtl/wave_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wave_capture_ctrl
// Purpose  : Zero-crossing-triggered capture of 256 audio samples into the
//            undisplayed half of a 512x8 waveform RAM, flipped on vblank.
//            Optional decimation: define WAVE_CAPTURE_DECIM_EN.
// Revision : 1.0
// ============================================================================
module wave_capture_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int DECIM    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_sample_ready,
    input  logic signed [SAMPLE_W-1:0] new_sample_in,
    input  logic                       wave_display_idle,
    output logic                       write_enable,
    output logic [8:0]                 write_address,
    output logic [7:0]                 write_sample,
    output logic                       read_index
);

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       read_index_q, read_index_d;
    logic       wen_q, wen_d;
    logic [8:0] waddr_q, waddr_d;
    logic [7:0] wsample_q, wsample_d;
    logic       prev_neg_q;
    logic       idle_q;

    logic       w_trigger;
    logic       w_idle_rise;
    logic       w_keep;
    logic [7:0] w_conv;
    logic       w_unused;

    // Only the sign of the previous sample matters for the crossing test.
    assign w_trigger   = new_sample_ready & prev_neg_q & ~new_sample_in[SAMPLE_W-1];
    assign w_idle_rise = wave_display_idle & ~idle_q;
    assign w_conv      = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
    assign w_unused    = (^new_sample_in[SAMPLE_W-9:0]) ^ (DECIM > 0);

`ifdef WAVE_CAPTURE_DECIM_EN
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [DW-1:0] decim_q;

    // Phase 0 is the trigger sample; every DECIM-th later sample is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            decim_q <= '0;
        end else if (state_q == ST_ARMED && w_trigger) begin
            decim_q <= '0;
        end else if (state_q == ST_ACTIVE && new_sample_ready) begin
            decim_q <= (decim_q == DW'(DECIM - 1)) ? '0 : decim_q + 1'b1;
        end
    end

    assign w_keep = (decim_q == DW'(DECIM - 1));
`else
    assign w_keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARMED: begin
                if (w_trigger) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready && w_keep && count_q == 8'hFF) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_idle_rise) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    always_comb begin
        count_d      = count_q;
        read_index_d = read_index_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wsample_d    = wsample_q;
        case (state_q)
            ST_ARMED: begin
                if (w_trigger) begin
                    wen_d     = 1'b1;
                    waddr_d   = {~read_index_q, 8'd0};
                    wsample_d = w_conv;
                    count_d   = 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready && w_keep) begin
                    wen_d     = 1'b1;
                    waddr_d   = {~read_index_q, count_q};
                    wsample_d = w_conv;
                    count_d   = count_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (w_idle_rise) begin
                    read_index_d = ~read_index_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= 8'd0;
            read_index_q <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= 9'd0;
            wsample_q    <= 8'd0;
            prev_neg_q   <= 1'b0;
            idle_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            read_index_q <= read_index_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wsample_q    <= wsample_d;
            idle_q       <= wave_display_idle;
            if (new_sample_ready) begin
                prev_neg_q <= new_sample_in[SAMPLE_W-1];
            end
        end
    end

    assign write_enable  = wen_q;
    assign write_address = waddr_q;
    assign write_sample  = wsample_q;
    assign read_index    = read_index_q;

endmodule
`default_nettype wire
